// File: rtl/ram_fifo_ctrl_pkg.sv
// fifo_pkg: constants and helpers shared by ram_fifo_ctrl and fifo_skid2.
//   SKID_DEPTH     : entries in the output skid buffer
//   RAM_RD_LATENCY : cycles from ram_rd_addr to ram_rd_q
//   skid_has_room  : read-issue gate; true when the words already committed to
//                    the skid (held + in flight - leaving) leave a free slot
package fifo_pkg;

  localparam int SKID_DEPTH     = 2;
  localparam int RAM_RD_LATENCY = 1;

  function automatic logic skid_has_room(input logic [1:0] skid_cnt,
                                         input logic       inflight,
                                         input logic       pop);
    logic [2:0] occ;
    occ = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, pop};
    return occ < 3'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if: push and pop handshakes of the RAM-backed FIFO.
//   in_valid/in_ready/in_data    : push side (producer -> FIFO)
//   out_valid/out_ready/out_data : pop side, show-ahead (FIFO -> consumer)
//   modport slave  : the FIFO view
//   modport master : the producer/consumer view
interface ram_fifo_ctrl_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/ram_fifo_ctrl_skid2.sv
// fifo_skid2: two-entry show-ahead buffer catching RAM read data.
//   clock, reset_n : clock, asynchronous active-low reset (clears data too)
//   flush          : synchronous empty, wins over push and pop
//   push/push_data : capture a word (caller never pushes when full)
//   pop            : drop the head word (caller never pops when empty)
//   head_data      : oldest word held
//   count          : words held, 0..2
module fifo_skid2
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // The head only moves on pop, so it stays stable while the consumer stalls.
  assign head_data = mem[rd_ptr];
  assign count     = cnt;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller around an external single-write/single-read
// RAM with 1-cycle registered read data, plus a 2-entry output skid.
//   clock, reset_n     : clock, asynchronous active-low reset
//   flush              : synchronous clear of all contents, beats everything
//   bus (slave)        : push / show-ahead pop handshakes
//   level              : words held (RAM + read in flight + skid)
//   ram_wr_*           : RAM write port, driven combinationally on push
//   ram_rd_addr/_q     : RAM read port, q returns one cycle after the address
module ram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter  int DEPTH      = 2048,
  parameter  int WIDTH      = 32,
  localparam int DEPTH_BITS = $clog2(DEPTH),
  localparam int BE_BITS    = WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  ram_fifo_ctrl_if.slave        bus,
  output logic [DEPTH_BITS+1:0] level,
  output logic [DEPTH_BITS-1:0] ram_wr_addr,
  output logic                  ram_wr_en,
  output logic [BE_BITS-1:0]    ram_wr_be,
  output logic [WIDTH-1:0]      ram_wr_data,
  output logic [DEPTH_BITS-1:0] ram_rd_addr,
  input  logic [WIDTH-1:0]      ram_rd_q
);

  localparam int LVL_W = DEPTH_BITS + 2;

  logic [DEPTH_BITS:0] wp;
  logic [DEPTH_BITS:0] rp;
  logic [DEPTH_BITS:0] ram_count;
  logic                full;
  logic                push;
  logic                pop;
  logic                rd_issue;
  logic                inflight_p1;
  logic [1:0]          skid_cnt;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  // ram_count uses the registered wp, so a word is readable only from the
  // cycle after it was written: no same-address read-during-write.
  assign ram_count = wp - rp;
  assign full      = (ram_count == (DEPTH_BITS + 1)'(DEPTH));

  assign bus.in_ready = !full && !flush && reset_n;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = bus.out_valid && bus.out_ready;

  // Issue a read only if the skid can take the word when it returns.
  assign rd_issue = (ram_count != '0) && !flush
                    && skid_has_room(skid_cnt, inflight_p1, pop);

  assign ram_wr_en   = push;
  assign ram_wr_addr = wp[DEPTH_BITS-1:0];
  assign ram_wr_data = bus.in_data;
  assign ram_wr_be   = {BE_BITS{1'b1}};
  assign ram_rd_addr = rp[DEPTH_BITS-1:0];

  // Stage p0 -> p1: pointer update and read issue; inflight_p1 marks q valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wp          <= '0;
      rp          <= '0;
      inflight_p1 <= 1'b0;
    end else if (flush) begin
      wp          <= '0;
      rp          <= '0;
      inflight_p1 <= 1'b0;
    end else begin
      if (push)     wp <= wp + 1'b1;
      if (rd_issue) rp <= rp + 1'b1;
      inflight_p1 <= rd_issue;
    end
  end

  // Stage p1 -> p2: returning RAM word lands in the skid buffer.
  fifo_skid2 #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (inflight_p1),
    .push_data (ram_rd_q),
    .pop       (pop),
    .head_data (bus.out_data),
    .count     (skid_cnt)
  );

  assign bus.out_valid = (skid_cnt != '0);

  assign level = LVL_W'(ram_count) + LVL_W'(inflight_p1) + LVL_W'(skid_cnt);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: bench for ram_fifo_ctrl with a small RAM model (DEPTH=8).
// Directed table for the first-push timing, then a word-queue reference model
// (each word tagged with the edge it was accepted on) for fill, stream,
// flush, random and reset sequences.
module tb_ram_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;
  localparam int DB    = $clog2(DEPTH);

  logic             clock;
  logic             reset_n;
  logic             flush;
  logic [DB+1:0]    level;
  logic [DB-1:0]    ram_wr_addr;
  logic             ram_wr_en;
  logic [3:0]       ram_wr_be;
  logic [WIDTH-1:0] ram_wr_data;
  logic [DB-1:0]    ram_rd_addr;
  logic [WIDTH-1:0] ram_rd_q;

  ram_fifo_ctrl_if #(.WIDTH(WIDTH)) bus ();

  ram_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .bus         (bus),
    .level       (level),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_be   (ram_wr_be),
    .ram_wr_data (ram_wr_data),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_q    (ram_rd_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // External RAM: byte-enabled write, registered read.
  logic [WIDTH-1:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = '0;
  always @(posedge clock) begin
    if (ram_wr_en)
      for (int b = 0; b < 4; b++)
        if (ram_wr_be[b]) ram[ram_wr_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
    ram_rd_q <= ram[ram_rd_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: words held, in order, with the edge they were accepted.
  typedef struct {
    logic [31:0] data;
    int          ts;
  } ent_t;
  ent_t mq[$];
  int   cyc = 0;

  task automatic step(input bit iv, input logic [31:0] d, input bit ordy,
                      input bit fl, output bit popped);
    bit acc;
    @(negedge clock);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    if (fl) chk("in_ready_flush", 64'(bus.in_ready), 64'(0));
    else if (mq.size() < DEPTH) chk("in_ready_room", 64'(bus.in_ready), 64'(1));
    else if (mq.size() >= DEPTH + 2) chk("in_ready_full", 64'(bus.in_ready), 64'(0));
    acc = iv && bus.in_ready;
    chk("wr_en", 64'(ram_wr_en), 64'(acc));
    if (acc) chk("wr_data", 64'(ram_wr_data), 64'(d));
    if (bus.out_valid) begin
      if (mq.size() == 0) chk("out_valid_empty", 64'(bus.out_valid), 64'(0));
      else chk("out_data", 64'(bus.out_data), 64'(mq[0].data));
    end
    if (mq.size() != 0 && cyc >= mq[0].ts + 2)
      chk("out_valid_latency", 64'(bus.out_valid), 64'(1));
    popped = bus.out_valid && ordy && !fl;
    @(posedge clock);
    if (fl) mq.delete();
    else begin
      if (popped) void'(mq.pop_front());
      if (acc) mq.push_back('{d, cyc + 1});
    end
    cyc++;
    #1;
    chk("level", 64'(level), 64'(mq.size()));
  endtask

  task automatic drain(input int n);
    bit p;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0, p);
    chk("drain_empty", 64'(level), 64'(0));
  endtask

  typedef struct {
    bit          iv;
    logic [31:0] din;
    bit          ordy;
    bit          e_ir;
    bit          e_we;
    logic [2:0]  e_addr;
    bit          e_ov;
    logic [31:0] e_od;
    int          e_lvl;
  } vec_t;
  vec_t vt[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit p;
    int pops;

    //          iv din           ordy ir we addr ov od            lvl
    vt[0] = '{1'b1, 32'h11223344, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 32'h0,        1};
    vt[1] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0,        1};
    vt[2] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 32'h11223344, 1};
    vt[3] = '{1'b1, 32'hAABBCCDD, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 32'h0,        1};
    vt[4] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0,        1};
    vt[5] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 32'hAABBCCDD, 1};
    vt[6] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0,        0};

    // Reset state, with a push request already pending.
    reset_n       = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h12345678;
    bus.out_ready = 1'b0;
    #3;
    chk("rst_in_ready",  64'(bus.in_ready),  64'(0));
    chk("rst_wr_en",     64'(ram_wr_en),     64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data",  64'(bus.out_data),  64'(0));
    chk("rst_level",     64'(level),         64'(0));
    bus.in_valid = 1'b0;
    @(posedge clock);
    #2 reset_n = 1'b1;

    // First push right after reset, then a push+pop overlap.
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      bus.in_valid  = vt[i].iv;
      bus.in_data   = vt[i].din;
      bus.out_ready = vt[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), 64'(bus.in_ready), 64'(vt[i].e_ir));
      chk($sformatf("v%0d_wr_en", i), 64'(ram_wr_en), 64'(vt[i].e_we));
      if (vt[i].e_we) begin
        chk($sformatf("v%0d_wr_addr", i), 64'(ram_wr_addr), 64'(vt[i].e_addr));
        chk($sformatf("v%0d_wr_be", i), 64'(ram_wr_be), 64'(4'hF));
      end
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_out_valid", i), 64'(bus.out_valid), 64'(vt[i].e_ov));
      if (vt[i].e_ov) chk($sformatf("v%0d_out_data", i), 64'(bus.out_data), 64'(vt[i].e_od));
      chk($sformatf("v%0d_level", i), 64'(level), 64'(vt[i].e_lvl));
    end

    // Fill with the consumer stalled; pushes beyond capacity must be refused.
    for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 32'hA000 + i, 1'b0, 1'b0, p);
    chk("fill_level", 64'(level), 64'(DEPTH + 2));
    for (int i = 0; i < 3; i++) step(1'b1, 32'hDEAD0000 + i, 1'b0, 1'b0, p);
    step(1'b1, 32'hBEEF0000, 1'b1, 1'b0, p);
    drain(2 * DEPTH + 4);

    // Continuous stream across several pointer wraps.
    pops = 0;
    for (int i = 0; i < 3 * DEPTH + 3; i++) begin
      step(i < 3 * DEPTH, 32'h1000 + i, 1'b1, 1'b0, p);
      if (p) pops++;
    end
    chk("stream_pops", 64'(pops), 64'(3 * DEPTH));

    // Flush with 5 words held and one read in flight.
    for (int i = 0; i < 6; i++) step(1'b1, 32'hF000 + i, 1'b0, 1'b0, p);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0, p);
    step(1'b0, 32'h0, 1'b1, 1'b0, p);
    chk("pre_flush_level", 64'(level), 64'(5));
    step(1'b1, 32'hF00D, 1'b1, 1'b1, p);
    chk("flush_out_valid", 64'(bus.out_valid), 64'(0));
    for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b1, 1'b0, p);
    step(1'b1, 32'hC0FFEE, 1'b0, 1'b0, p);
    step(1'b0, 32'h0, 1'b0, 1'b0, p);
    chk("post_flush_not_yet", 64'(bus.out_valid), 64'(0));
    step(1'b0, 32'h0, 1'b0, 1'b0, p);
    chk("post_flush_valid", 64'(bus.out_valid), 64'(1));
    chk("post_flush_data", 64'(bus.out_data), 64'(32'hC0FFEE));
    drain(DEPTH);

    // Random traffic with rare flushes.
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           $urandom_range(0, 255) == 0, p);
    drain(2 * DEPTH + 4);

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 6; i++) step(1'b1, 32'h5000 + i, i > 2, 1'b0, p);
    @(negedge clock);
    bus.in_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  64'(bus.in_ready),  64'(0));
    chk("mid_rst_wr_en",     64'(ram_wr_en),     64'(0));
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_out_data",  64'(bus.out_data),  64'(0));
    chk("mid_rst_level",     64'(level),         64'(0));
    mq.delete();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clock);
    #2 reset_n = 1'b1;
    step(1'b1, 32'h6000, 1'b0, 1'b0, p);
    chk("post_rst_level", 64'(level), 64'(1));
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0, p);
    drain(2 * DEPTH + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
